// File: rtl/exe_issue_queue.sv
// Reservation station ahead of EXE: holds dispatched ops until both source operands are
// known, captures operands from the result broadcast, and issues the oldest ready op per cycle.
module exe_issue_queue #(
  parameter int DEPTH = 8,
  parameter int TAG_W = 6
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             Flush_IN,
  input  logic             Disp_Valid_IN,
  input  logic [31:0]      Disp_Instr_IN,
  input  logic [31:0]      Disp_PC_IN,
  input  logic [TAG_W-1:0] Disp_SrcA_IN,
  input  logic             Disp_SrcA_Rdy_IN,
  input  logic [31:0]      Disp_OpA_IN,
  input  logic [TAG_W-1:0] Disp_SrcB_IN,
  input  logic             Disp_SrcB_Rdy_IN,
  input  logic [31:0]      Disp_OpB_IN,
  input  logic [TAG_W-1:0] Disp_WriteRegister_IN,
  input  logic             Disp_RegWrite_IN,
  input  logic [5:0]       Disp_ALU_Control_IN,
  input  logic             Disp_MemRead_IN,
  input  logic             Disp_MemWrite_IN,
  input  logic [4:0]       Disp_ShiftAmount_IN,
  input  logic [31:0]      Disp_InstrAge_IN,
  output logic             Full_OUT,
  input  logic             CDB_Valid_IN,
  input  logic [TAG_W-1:0] CDB_Tag_IN,
  input  logic [31:0]      CDB_Data_IN,
  input  logic             IF_stall_request,
  output logic             Issue_Valid_OUT,
  output logic [31:0]      Instr1_OUT,
  output logic [31:0]      Instr1_PC_OUT,
  output logic [31:0]      OperandA1_OUT,
  output logic [31:0]      OperandB1_OUT,
  output logic [TAG_W-1:0] WriteRegister1_OUT,
  output logic [5:0]       ALU_Control1_OUT,
  output logic             RegWrite1_OUT,
  output logic             MemRead1_OUT,
  output logic             MemWrite1_OUT,
  output logic [4:0]       ShiftAmount1_OUT,
  output logic [31:0]      InstrAge_OUT
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef struct packed {
    logic             valid;
    logic [31:0]      instr;
    logic [31:0]      pc;
    logic [TAG_W-1:0] src_a;
    logic             rdy_a;
    logic [31:0]      op_a;
    logic [TAG_W-1:0] src_b;
    logic             rdy_b;
    logic [31:0]      op_b;
    logic [TAG_W-1:0] wreg;
    logic             regwrite;
    logic [5:0]       alu_ctrl;
    logic             memread;
    logic             memwrite;
    logic [4:0]       shamt;
    logic [31:0]      age;
  } entry_t;

  entry_t           q   [DEPTH];
  entry_t           q_n [DEPTH];
  entry_t           disp_entry;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_n;
  logic             sel_found;
  logic [IDX_W-1:0] sel_idx;
  logic [31:0]      sel_age;
  logic [IDX_W-1:0] free_idx;
  logic             disp_acc;
  logic             issue_fire;

  // Full is judged on the registered count, so a same-cycle issue never admits a dispatch.
  assign Full_OUT   = (count == DEPTH_C);
  assign disp_acc   = Disp_Valid_IN && !Full_OUT;
  assign issue_fire = sel_found && !IF_stall_request;

  always_comb begin
    disp_entry          = '0;
    disp_entry.valid    = 1'b1;
    disp_entry.instr    = Disp_Instr_IN;
    disp_entry.pc       = Disp_PC_IN;
    disp_entry.src_a    = Disp_SrcA_IN;
    disp_entry.src_b    = Disp_SrcB_IN;
    disp_entry.wreg     = Disp_WriteRegister_IN;
    disp_entry.regwrite = Disp_RegWrite_IN;
    disp_entry.alu_ctrl = Disp_ALU_Control_IN;
    disp_entry.memread  = Disp_MemRead_IN;
    disp_entry.memwrite = Disp_MemWrite_IN;
    disp_entry.shamt    = Disp_ShiftAmount_IN;
    disp_entry.age      = Disp_InstrAge_IN;
    if (Disp_SrcA_Rdy_IN || (Disp_SrcA_IN == '0)) begin
      disp_entry.rdy_a = 1'b1;
      disp_entry.op_a  = Disp_OpA_IN;
    end else if (CDB_Valid_IN && (CDB_Tag_IN == Disp_SrcA_IN)) begin
      disp_entry.rdy_a = 1'b1;
      disp_entry.op_a  = CDB_Data_IN;
    end
    if (Disp_SrcB_Rdy_IN || (Disp_SrcB_IN == '0)) begin
      disp_entry.rdy_b = 1'b1;
      disp_entry.op_b  = Disp_OpB_IN;
    end else if (CDB_Valid_IN && (CDB_Tag_IN == Disp_SrcB_IN)) begin
      disp_entry.rdy_b = 1'b1;
      disp_entry.op_b  = CDB_Data_IN;
    end
  end

  // Oldest-ready select over the pre-edge state.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_age   = '1;
    for (int i = 0; i < DEPTH; i++) begin
      if (q[i].valid && q[i].rdy_a && q[i].rdy_b && (!sel_found || (q[i].age < sel_age))) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
        sel_age   = q[i].age;
      end
    end
  end

  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!q[i].valid) free_idx = IDX_W'(i);
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      q_n[i] = q[i];
      if (q[i].valid && CDB_Valid_IN) begin
        if (!q[i].rdy_a && (q[i].src_a == CDB_Tag_IN)) begin
          q_n[i].rdy_a = 1'b1;
          q_n[i].op_a  = CDB_Data_IN;
        end
        if (!q[i].rdy_b && (q[i].src_b == CDB_Tag_IN)) begin
          q_n[i].rdy_b = 1'b1;
          q_n[i].op_b  = CDB_Data_IN;
        end
      end
    end
    if (issue_fire) q_n[sel_idx].valid = 1'b0;
    if (disp_acc)   q_n[free_idx]      = disp_entry;
  end

  always_comb begin
    case ({disp_acc, issue_fire})
      2'b10:   count_n = count + CNT_W'(1);
      2'b01:   count_n = count - CNT_W'(1);
      default: count_n = count;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET || Flush_IN) begin
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
      count              <= '0;
      Issue_Valid_OUT    <= 1'b0;
      Instr1_OUT         <= '0;
      Instr1_PC_OUT      <= '0;
      OperandA1_OUT      <= '0;
      OperandB1_OUT      <= '0;
      WriteRegister1_OUT <= '0;
      ALU_Control1_OUT   <= '0;
      RegWrite1_OUT      <= 1'b0;
      MemRead1_OUT       <= 1'b0;
      MemWrite1_OUT      <= 1'b0;
      ShiftAmount1_OUT   <= '0;
      InstrAge_OUT       <= '0;
    end else begin
      q     <= q_n;
      count <= count_n;
      if (!IF_stall_request) begin
        if (sel_found) begin
          Issue_Valid_OUT    <= 1'b1;
          Instr1_OUT         <= q[sel_idx].instr;
          Instr1_PC_OUT      <= q[sel_idx].pc;
          OperandA1_OUT      <= q[sel_idx].op_a;
          OperandB1_OUT      <= q[sel_idx].op_b;
          WriteRegister1_OUT <= q[sel_idx].wreg;
          ALU_Control1_OUT   <= q[sel_idx].alu_ctrl;
          RegWrite1_OUT      <= q[sel_idx].regwrite;
          MemRead1_OUT       <= q[sel_idx].memread;
          MemWrite1_OUT      <= q[sel_idx].memwrite;
          ShiftAmount1_OUT   <= q[sel_idx].shamt;
          InstrAge_OUT       <= q[sel_idx].age;
        end else begin
          Issue_Valid_OUT    <= 1'b0;
          Instr1_OUT         <= '0;
          Instr1_PC_OUT      <= '0;
          OperandA1_OUT      <= '0;
          OperandB1_OUT      <= '0;
          WriteRegister1_OUT <= '0;
          ALU_Control1_OUT   <= '0;
          RegWrite1_OUT      <= 1'b0;
          MemRead1_OUT       <= 1'b0;
          MemWrite1_OUT      <= 1'b0;
          ShiftAmount1_OUT   <= '0;
          InstrAge_OUT       <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_exe_issue_queue.sv
// Directed bench for exe_issue_queue: a vector table for the basic flows plus hand-written
// sequences for full, stall-hold, flush and mid-operation reset.
module tb_exe_issue_queue;

  logic        CLK = 1'b0;
  logic        RESET, Flush_IN, Disp_Valid_IN;
  logic [31:0] Disp_Instr_IN, Disp_PC_IN, Disp_OpA_IN, Disp_OpB_IN, Disp_InstrAge_IN;
  logic [5:0]  Disp_SrcA_IN, Disp_SrcB_IN, Disp_WriteRegister_IN, Disp_ALU_Control_IN;
  logic        Disp_SrcA_Rdy_IN, Disp_SrcB_Rdy_IN, Disp_RegWrite_IN, Disp_MemRead_IN, Disp_MemWrite_IN;
  logic [4:0]  Disp_ShiftAmount_IN;
  logic        Full_OUT, CDB_Valid_IN, IF_stall_request;
  logic [5:0]  CDB_Tag_IN;
  logic [31:0] CDB_Data_IN;
  logic        Issue_Valid_OUT, RegWrite1_OUT, MemRead1_OUT, MemWrite1_OUT;
  logic [31:0] Instr1_OUT, Instr1_PC_OUT, OperandA1_OUT, OperandB1_OUT, InstrAge_OUT;
  logic [5:0]  WriteRegister1_OUT, ALU_Control1_OUT;
  logic [4:0]  ShiftAmount1_OUT;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  exe_issue_queue #(.DEPTH(8), .TAG_W(6)) dut (
    .CLK(CLK), .RESET(RESET), .Flush_IN(Flush_IN),
    .Disp_Valid_IN(Disp_Valid_IN), .Disp_Instr_IN(Disp_Instr_IN), .Disp_PC_IN(Disp_PC_IN),
    .Disp_SrcA_IN(Disp_SrcA_IN), .Disp_SrcA_Rdy_IN(Disp_SrcA_Rdy_IN), .Disp_OpA_IN(Disp_OpA_IN),
    .Disp_SrcB_IN(Disp_SrcB_IN), .Disp_SrcB_Rdy_IN(Disp_SrcB_Rdy_IN), .Disp_OpB_IN(Disp_OpB_IN),
    .Disp_WriteRegister_IN(Disp_WriteRegister_IN), .Disp_RegWrite_IN(Disp_RegWrite_IN),
    .Disp_ALU_Control_IN(Disp_ALU_Control_IN), .Disp_MemRead_IN(Disp_MemRead_IN),
    .Disp_MemWrite_IN(Disp_MemWrite_IN), .Disp_ShiftAmount_IN(Disp_ShiftAmount_IN),
    .Disp_InstrAge_IN(Disp_InstrAge_IN), .Full_OUT(Full_OUT),
    .CDB_Valid_IN(CDB_Valid_IN), .CDB_Tag_IN(CDB_Tag_IN), .CDB_Data_IN(CDB_Data_IN),
    .IF_stall_request(IF_stall_request), .Issue_Valid_OUT(Issue_Valid_OUT),
    .Instr1_OUT(Instr1_OUT), .Instr1_PC_OUT(Instr1_PC_OUT),
    .OperandA1_OUT(OperandA1_OUT), .OperandB1_OUT(OperandB1_OUT),
    .WriteRegister1_OUT(WriteRegister1_OUT), .ALU_Control1_OUT(ALU_Control1_OUT),
    .RegWrite1_OUT(RegWrite1_OUT), .MemRead1_OUT(MemRead1_OUT), .MemWrite1_OUT(MemWrite1_OUT),
    .ShiftAmount1_OUT(ShiftAmount1_OUT), .InstrAge_OUT(InstrAge_OUT)
  );

  typedef struct {
    bit          dv;
    logic [31:0] age;
    logic [5:0]  sa;
    bit          ra;
    logic [31:0] oa;
    logic [5:0]  sb;
    bit          rb;
    logic [31:0] ob;
    bit          cv;
    logic [5:0]  ct;
    logic [31:0] cd;
    bit          st;
    bit          fl;
    bit          ev;
    logic [31:0] eage;
    logic [31:0] eopa;
    logic [31:0] eopb;
    bit          efull;
  } vec_t;

  vec_t vecs[$];

  // Side-band fields of each op are derived from its age so any issued op is self-identifying.
  function automatic logic [31:0] instr_of(logic [31:0] a); return 32'hA500_0000 + a; endfunction
  function automatic logic [31:0] pc_of(logic [31:0] a); return 32'h0040_0000 + (a << 2); endfunction
  function automatic logic [5:0] alu_of(logic [31:0] a);
    logic [31:0] t;
    t = ~a;
    return t[5:0];
  endfunction
  function automatic logic [4:0] sh_of(logic [31:0] a);
    logic [31:0] t;
    t = a + 32'd1;
    return t[4:0];
  endfunction

  function automatic vec_t mkv(int dv, int age, int sa, int ra, int oa, int sb, int rb, int ob,
                               int cv, int ct, int cd, int st, int fl);
    vec_t v;
    v.dv = dv[0]; v.age = age; v.sa = 6'(sa); v.ra = ra[0]; v.oa = oa;
    v.sb = 6'(sb); v.rb = rb[0]; v.ob = ob;
    v.cv = cv[0]; v.ct = 6'(ct); v.cd = cd; v.st = st[0]; v.fl = fl[0];
    v.ev = 1'b0; v.eage = '0; v.eopa = '0; v.eopb = '0; v.efull = 1'b0;
    return v;
  endfunction

  function automatic vec_t ex(vec_t vi, int ev, int eage, int eopa, int eopb, int ef);
    vec_t v;
    v = vi;
    v.ev = ev[0]; v.eage = eage; v.eopa = eopa; v.eopb = eopb; v.efull = ef[0];
    return v;
  endfunction

  function automatic vec_t idle();
    return mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  task automatic apply(input vec_t v);
    Disp_Valid_IN         = v.dv;
    Disp_InstrAge_IN      = v.age;
    Disp_Instr_IN         = instr_of(v.age);
    Disp_PC_IN            = pc_of(v.age);
    Disp_WriteRegister_IN = v.age[5:0];
    Disp_RegWrite_IN      = v.age[0];
    Disp_ALU_Control_IN   = alu_of(v.age);
    Disp_MemRead_IN       = v.age[1];
    Disp_MemWrite_IN      = v.age[2];
    Disp_ShiftAmount_IN   = sh_of(v.age);
    Disp_SrcA_IN          = v.sa;
    Disp_SrcA_Rdy_IN      = v.ra;
    Disp_OpA_IN           = v.oa;
    Disp_SrcB_IN          = v.sb;
    Disp_SrcB_Rdy_IN      = v.rb;
    Disp_OpB_IN           = v.ob;
    CDB_Valid_IN          = v.cv;
    CDB_Tag_IN            = v.ct;
    CDB_Data_IN           = v.cd;
    IF_stall_request      = v.st;
    Flush_IN              = v.fl;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic chk_out(input string nm, input vec_t v);
    logic [31:0] a;
    a = v.ev ? v.eage : 32'd0;
    chk({nm, ".valid"}, 32'(Issue_Valid_OUT), 32'(v.ev));
    chk({nm, ".full"},  32'(Full_OUT), 32'(v.efull));
    chk({nm, ".age"},   InstrAge_OUT, a);
    chk({nm, ".opa"},   OperandA1_OUT, v.ev ? v.eopa : 32'd0);
    chk({nm, ".opb"},   OperandB1_OUT, v.ev ? v.eopb : 32'd0);
    chk({nm, ".instr"}, Instr1_OUT, v.ev ? instr_of(a) : 32'd0);
    chk({nm, ".pc"},    Instr1_PC_OUT, v.ev ? pc_of(a) : 32'd0);
    chk({nm, ".wreg"},  32'(WriteRegister1_OUT), v.ev ? 32'(a[5:0]) : 32'd0);
    chk({nm, ".alu"},   32'(ALU_Control1_OUT), v.ev ? 32'(alu_of(a)) : 32'd0);
    chk({nm, ".ctl"},   {29'd0, RegWrite1_OUT, MemRead1_OUT, MemWrite1_OUT},
                        v.ev ? {29'd0, a[0], a[1], a[2]} : 32'd0);
    chk({nm, ".shamt"}, 32'(ShiftAmount1_OUT), v.ev ? 32'(sh_of(a)) : 32'd0);
  endtask

  task automatic run(input string nm, input vec_t v);
    apply(v);
    @(posedge CLK);
    #1;
    chk_out(nm, v);
  endtask

  initial begin
    RESET = 1'b1;
    // Reset dominates a dispatch presented at the same edges.
    run("reset0", mkv(1, 5, 1, 1, 3, 2, 1, 4, 0, 0, 0, 0, 0));
    run("reset1", mkv(1, 6, 1, 1, 3, 2, 1, 4, 0, 0, 0, 0, 0));
    RESET = 1'b0;
    chk("reset.count", 32'(dut.count), 32'd0);

    // Ready op, wakeup two cycles later, stalled dispatch order, tag 0, same-cycle capture.
    vecs.push_back(ex(mkv(1, 5, 1, 1, 3, 2, 1, 4, 0, 0, 0, 0, 0), 0, 0, 0, 0, 0));
    vecs.push_back(ex(idle(), 1, 5, 3, 4, 0));
    vecs.push_back(ex(idle(), 0, 0, 0, 0, 0));
    vecs.push_back(ex(mkv(1, 7, 12, 0, 0, 0, 1, 'h55, 0, 0, 0, 0, 0), 0, 0, 0, 0, 0));
    vecs.push_back(ex(mkv(0, 0, 0, 0, 0, 0, 0, 0, 1, 13, 'hBB, 0, 0), 0, 0, 0, 0, 0));
    vecs.push_back(ex(mkv(0, 0, 0, 0, 0, 0, 0, 0, 1, 12, 'hAA, 0, 0), 0, 0, 0, 0, 0));
    vecs.push_back(ex(idle(), 1, 7, 'hAA, 'h55, 0));
    vecs.push_back(ex(idle(), 0, 0, 0, 0, 0));
    vecs.push_back(ex(mkv(1, 9, 1, 1, 9, 2, 1, 'h109, 0, 0, 0, 1, 0), 0, 0, 0, 0, 0));
    vecs.push_back(ex(mkv(1, 4, 1, 1, 4, 2, 1, 'h104, 0, 0, 0, 1, 0), 0, 0, 0, 0, 0));
    vecs.push_back(ex(mkv(1, 6, 1, 1, 6, 2, 1, 'h106, 0, 0, 0, 1, 0), 0, 0, 0, 0, 0));
    vecs.push_back(ex(idle(), 1, 4, 4, 'h104, 0));
    vecs.push_back(ex(idle(), 1, 6, 6, 'h106, 0));
    vecs.push_back(ex(idle(), 1, 9, 9, 'h109, 0));
    vecs.push_back(ex(idle(), 0, 0, 0, 0, 0));
    vecs.push_back(ex(mkv(1, 20, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0, 0, 0));
    vecs.push_back(ex(idle(), 1, 20, 0, 0, 0));
    vecs.push_back(ex(mkv(1, 30, 9, 0, 0, 10, 0, 0, 1, 9, 'h99, 0, 0), 0, 0, 0, 0, 0));
    vecs.push_back(ex(mkv(0, 0, 0, 0, 0, 0, 0, 0, 1, 10, 'h1010, 0, 0), 0, 0, 0, 0, 0));
    vecs.push_back(ex(idle(), 1, 30, 'h99, 'h1010, 0));
    vecs.push_back(ex(mkv(1, 31, 5, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0, 0, 0));
    vecs.push_back(ex(mkv(0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 'h77, 0, 0), 0, 0, 0, 0, 0));
    vecs.push_back(ex(idle(), 1, 31, 'h77, 'h77, 0));
    vecs.push_back(ex(idle(), 0, 0, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) run($sformatf("vec%0d", i), vecs[i]);

    // Fill to full; older ready op offered while full must be dropped.
    for (int k = 0; k < 8; k++)
      run($sformatf("fill%0d", k), ex(mkv(1, 100 + k, 40, 0, 0, 0, 1, 5, 0, 0, 0, 0, 0),
                                      0, 0, 0, 0, (k == 7) ? 1 : 0));
    run("full.drop", ex(mkv(1, 50, 1, 1, 50, 2, 1, 50, 0, 0, 0, 0, 0), 0, 0, 0, 0, 1));
    chk("full.count", 32'(dut.count), 32'd8);
    run("full.idle", ex(idle(), 0, 0, 0, 0, 1));
    run("full.wake", ex(mkv(0, 0, 0, 0, 0, 0, 0, 0, 1, 40, 'h40, 0, 0), 0, 0, 0, 0, 1));
    run("full.issue_drop", ex(mkv(1, 60, 1, 1, 60, 2, 1, 60, 0, 0, 0, 0, 0), 1, 100, 'h40, 5, 0));
    run("full.next", ex(idle(), 1, 101, 'h40, 5, 0));
    run("full.flush", ex(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), 0, 0, 0, 0, 0));
    chk("full.flush_count", 32'(dut.count), 32'd0);

    // Stall holds the issued op; dispatch continues underneath.
    run("st.d3", ex(mkv(1, 3, 1, 1, 3, 2, 1, 'h103, 0, 0, 0, 0, 0), 0, 0, 0, 0, 0));
    run("st.d8", ex(mkv(1, 8, 1, 1, 8, 2, 1, 'h108, 0, 0, 0, 0, 0), 1, 3, 3, 'h103, 0));
    run("st.h1", ex(mkv(1, 2, 1, 1, 2, 2, 1, 'h102, 0, 0, 0, 1, 0), 1, 3, 3, 'h103, 0));
    run("st.h2", ex(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), 1, 3, 3, 'h103, 0));
    run("st.h3", ex(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), 1, 3, 3, 'h103, 0));
    run("st.rel", ex(idle(), 1, 2, 2, 'h102, 0));
    run("st.next", ex(idle(), 1, 8, 8, 'h108, 0));
    run("st.empty", ex(idle(), 0, 0, 0, 0, 0));

    // Flush with a simultaneous dispatch: everything discarded, next dispatch accepted.
    for (int k = 0; k < 5; k++)
      run($sformatf("fl.d%0d", k), ex(mkv(1, 80 + k, 41, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), 0, 0, 0, 0, 0));
    chk("fl.count5", 32'(dut.count), 32'd5);
    run("fl.flush", ex(mkv(1, 70, 1, 1, 70, 2, 1, 70, 1, 41, 1, 1, 1), 0, 0, 0, 0, 0));
    chk("fl.count0", 32'(dut.count), 32'd0);
    run("fl.wake", ex(mkv(0, 0, 0, 0, 0, 0, 0, 0, 1, 41, 'h41, 0, 0), 0, 0, 0, 0, 0));
    run("fl.idle", ex(idle(), 0, 0, 0, 0, 0));
    run("fl.d71", ex(mkv(1, 71, 1, 1, 71, 2, 1, 'h171, 0, 0, 0, 0, 0), 0, 0, 0, 0, 0));
    run("fl.i71", ex(idle(), 1, 71, 71, 'h171, 0));

    // Reset in the middle of traffic.
    run("rs.d90", ex(mkv(1, 90, 1, 1, 90, 2, 1, 'h190, 0, 0, 0, 0, 0), 0, 0, 0, 0, 0));
    run("rs.d91", ex(mkv(1, 91, 1, 1, 91, 2, 1, 'h191, 0, 0, 0, 0, 0), 1, 90, 90, 'h190, 0));
    RESET = 1'b1;
    run("rs.reset", ex(idle(), 0, 0, 0, 0, 0));
    RESET = 1'b0;
    run("rs.after", ex(idle(), 0, 0, 0, 0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
